// File: rtl/rf_pkg.sv
// Shared register-file constants used by the decode and writeback stages.
package rf_pkg;

  localparam int unsigned RF_WIDTH   = 32;
  localparam int unsigned RF_DEPTH   = 32;
  localparam int unsigned REG_ADDR_W = $clog2(RF_DEPTH);
  localparam int unsigned ZERO_REG   = 0;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: tracks pending producers per register, gates issue on WAW
// hazards and reports RAW hazards on the read ports.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned  DEPTH  = RF_DEPTH,
  parameter int unsigned  NUM_RD = 2,
  parameter bit           BYPASS = 1'b1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic                       alloc_en,
  input  logic [AW-1:0]              alloc_addr,
  input  logic [NUM_RD-1:0][AW-1:0]  rd_addr,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic                       alloc_ok,
  output logic                       stall,
  output logic [AW:0]                busy_cnt
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic             wr_live;
  logic             alloc_tgt_busy;
  logic             alloc_set;

  assign wr_live = wr_en && !reset && (wr_addr != AW'(ZERO_REG));

  // A same-cycle writeback retires the producer before the consumer sees it
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
    assign rd_busy[i] = !reset && busy[rd_addr[i]] &&
                        !(BYPASS && wr_live && (wr_addr == rd_addr[i]));
  end

  assign alloc_tgt_busy = busy[alloc_addr] &&
                          !(BYPASS && wr_live && (wr_addr == alloc_addr));
  assign alloc_ok       = alloc_en && !reset && !alloc_tgt_busy;
  assign alloc_set      = alloc_ok && (alloc_addr != AW'(ZERO_REG));
  assign stall          = !reset && ((|rd_busy) || (alloc_en && !alloc_ok));

  // Clear on writeback first, then set on allocation so a new producer wins
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    if (wr_live) busy_nxt[wr_addr] = 1'b0;
    if (alloc_set) busy_nxt[alloc_addr] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[AW'(j)]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule : rf_scoreboard

// File: rtl/regfile_scoreboard.sv
// Register file with hard-wired zero register, optional write-to-read forwarding
// and an attached busy-bit scoreboard for hazard detection.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned  WIDTH  = RF_WIDTH,
  parameter int unsigned  DEPTH  = RF_DEPTH,
  parameter int unsigned  NUM_RD = 2,
  parameter bit           BYPASS = 1'b1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         alloc_en,
  input  logic [AW-1:0]                alloc_addr,
  output logic                         alloc_ok,
  output logic                         stall,
  output logic [AW:0]                  busy_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_live;

  assign wr_live = wr_en && !reset && (wr_addr != AW'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem[AW'(k)] <= '0;
    end else if (wr_live) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read ports; register 0 always reads zero
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic fwd_hit;
    assign fwd_hit    = BYPASS && wr_live && (wr_addr == rd_addr[i]);
    assign rd_data[i] = (rd_addr[i] == AW'(ZERO_REG)) ? '0 :
                        fwd_hit                       ? wr_data :
                                                        mem[rd_addr[i]];
  end

  rf_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy),
    .alloc_ok   (alloc_ok),
    .stall      (stall),
    .busy_cnt   (busy_cnt)
  );

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: two DUTs (forwarding on/off) share stimulus; expectations come
// from a register-file model and are checked by an independent monitor.
module tb_regfile_scoreboard;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic [1:0][4:0]  rd_addr;
  logic             alloc_en;
  logic [4:0]       alloc_addr;

  logic [1:0][31:0] rd_data_a, rd_data_b;
  logic [1:0]       rd_busy_a, rd_busy_b;
  logic             alloc_ok_a, alloc_ok_b, stall_a, stall_b;
  logic [5:0]       busy_cnt_a, busy_cnt_b;

  always #5 clk = ~clk;

  regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1'b1)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ok(alloc_ok_a),
    .stall(stall_a), .busy_cnt(busy_cnt_a)
  );

  regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ok(alloc_ok_b),
    .stall(stall_b), .busy_cnt(busy_cnt_b)
  );

  typedef struct {
    int          step;
    logic [31:0] rd  [2][2];
    logic        rb  [2][2];
    logic        aok [2];
    logic        stl [2];
    int          cnt [2];
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] mmem  [32];
  logic [31:0] mbusy [2];   // index 0: forwarding model, 1: no forwarding
  int          n_checks = 0;
  int          n_pass   = 0;
  int          step     = 0;

  task automatic chk(input string name, input int st, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, st, act, req);
  endtask

  // One clock of stimulus; the model predicts this cycle's outputs, then advances
  task automatic cycle(input bit rst, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input bit ae, input logic [4:0] aa,
                       input logic [4:0] r0, input logic [4:0] r1);
    exp_t       e;
    logic [4:0] ra [2];
    bit         bp, hit;
    @(posedge clk); #1;
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    alloc_en = ae; alloc_addr = aa; rd_addr[0] = r0; rd_addr[1] = r1;
    ra[0] = r0; ra[1] = r1;
    e.step = step++;
    for (int b = 0; b < 2; b++) begin
      bp = (b == 0);
      for (int i = 0; i < 2; i++) begin
        hit = bp && !rst && we && (wa != 0) && (wa == ra[i]);
        e.rd[b][i] = (ra[i] == 0) ? 32'h0 : (hit ? wd : mmem[ra[i]]);
        e.rb[b][i] = !rst && mbusy[b][ra[i]] && !hit;
      end
      hit = bp && !rst && we && (wa != 0) && (wa == aa);
      e.aok[b] = !rst && ae && !(mbusy[b][aa] && !hit);
      e.stl[b] = !rst && (e.rb[b][0] || e.rb[b][1] || (ae && !e.aok[b]));
      e.cnt[b] = $countones(mbusy[b]);
    end
    exp_q.push_back(e);
    if (rst) begin
      for (int k = 0; k < 32; k++) mmem[k] = 32'h0;
      mbusy[0] = 32'h0; mbusy[1] = 32'h0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (we && wa != 0) mbusy[b][wa] = 1'b0;
        if (e.aok[b] && aa != 0) mbusy[b][aa] = 1'b1;
      end
      if (we && wa != 0) mmem[wa] = wd;
    end
  endtask

  task automatic idle_read(input logic [4:0] r0, input logic [4:0] r1);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
  endtask

  // Monitor: every issued cycle is checked mid-cycle on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("rd_data_a[%0d]", i), e.step, rd_data_a[i], e.rd[0][i]);
          chk($sformatf("rd_data_b[%0d]", i), e.step, rd_data_b[i], e.rd[1][i]);
          chk($sformatf("rd_busy_a[%0d]", i), e.step, 32'(rd_busy_a[i]), 32'(e.rb[0][i]));
          chk($sformatf("rd_busy_b[%0d]", i), e.step, 32'(rd_busy_b[i]), 32'(e.rb[1][i]));
        end
        chk("alloc_ok_a", e.step, 32'(alloc_ok_a), 32'(e.aok[0]));
        chk("alloc_ok_b", e.step, 32'(alloc_ok_b), 32'(e.aok[1]));
        chk("stall_a", e.step, 32'(stall_a), 32'(e.stl[0]));
        chk("stall_b", e.step, 32'(stall_b), 32'(e.stl[1]));
        chk("busy_cnt_a", e.step, 32'(busy_cnt_a), 32'(e.cnt[0]));
        chk("busy_cnt_b", e.step, 32'(busy_cnt_b), 32'(e.cnt[1]));
      end
    end
  end

  initial begin
    int guard;
    for (int k = 0; k < 32; k++) mmem[k] = 32'h0;
    mbusy[0] = 32'h0; mbusy[1] = 32'h0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;
    @(posedge clk);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd1);

    // Every register reads zero and idle after reset
    for (int a = 0; a < 32; a += 2) idle_read(5'(a), 5'(a + 1));

    // Plain writes, zero register
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    idle_read(5'd5, 5'd5);
    cycle(1'b0, 1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 5'd0, 5'd0);
    idle_read(5'd0, 5'd5);

    // Same-cycle forwarding
    cycle(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd7);
    idle_read(5'd7, 5'd0);

    // RAW / WAW hazards on x3
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd0);
    idle_read(5'd3, 5'd4);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
    cycle(1'b0, 1'b1, 5'd3, 32'h33333333, 1'b0, 5'd0, 5'd3, 5'd0);
    idle_read(5'd3, 5'd3);

    // Alloc and writeback collide on busy x9
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd9, 32'h99999999, 1'b1, 5'd9, 5'd9, 5'd0);
    idle_read(5'd9, 5'd0);
    cycle(1'b0, 1'b1, 5'd9, 32'h0000AAAA, 1'b0, 5'd0, 5'd9, 5'd0);
    idle_read(5'd9, 5'd0);

    // Reset discards pending allocations
    for (int a = 1; a <= 4; a++) cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 5'd1, 5'd2);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd1, 5'd2);
    cycle(1'b1, 1'b1, 5'd2, 32'h77, 1'b1, 5'd6, 5'd2, 5'd3);
    cycle(1'b0, 1'b1, 5'd2, 32'h55, 1'b0, 5'd0, 5'd2, 5'd1);
    idle_read(5'd2, 5'd4);

    // Randomised traffic on a small register window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
            5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end
    idle_read(5'd1, 5'd2);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_regfile_scoreboard
